sht21_bcd_convert: RTL

Sequential converter that turns a raw 16-bit SHT21 measurement word into signed, fixed-point, BCD display digits in hundredths of °C or hundredths of %RH. It sits between the I2C read controller, which supplies `readData` plus a start pulse, and the seven-segment display driver, which consumes `displaydata`. The datapath is a shift-add multiplier and a double-dabble BCD stage. There are no vendor IP cores. The block adds a start/done handshake, a sign flag, overflow saturation and a parametrised digit count.

---
 rtl/sht21_bcd_convert.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sht21_bcd_convert.sv
// SHT21 raw word to signed fixed-point BCD (hundredths of degC or %RH).
// Shift-add multiply, offset subtract with sign/clamp, then double-dabble.
module sht21_bcd_convert #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  com_sig,
    input  logic [15:0]           readData,
    output logic                  busy,
    output logic                  done,
    output logic                  negative,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   displaydata,
    output logic [2:0]            dbg_state
);

    localparam int DW = 4 * DIGITS;
    // The BCD work field is fixed at 6 digits so any legal DIGITS can be sliced from it.
    localparam int BW = 24;

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned LIMIT = pow10(DIGITS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_SUB  = 3'd2,
        S_BCD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic         is_temp;
    logic [15:0]  mplier;
    logic [30:0]  mcand;
    logic [30:0]  acc;
    logic [13:0]  mag;
    logic         neg_r;
    logic         ovf_r;
    logic [BW-1:0] bcd;

    logic [BW-1:0] bcd_adj;
    logic [15:0]   offset;
    logic [15:0]   r_diff;
    logic [15:0]   r_abs;
    logic [13:0]   mag_next;
    logic          neg_next;
    logic          ovf_next;

    assign dbg_state = state;

    // Add-3 correction applied before each double-dabble shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BW / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        offset   = is_temp ? 16'd4685 : 16'd600;
        r_diff   = {1'b0, acc[30:16]} - offset;
        r_abs    = 16'd0 - r_diff;
        mag_next = r_diff[13:0];
        neg_next = 1'b0;
        if (r_diff[15]) begin
            // Below zero: temperature reports magnitude, humidity clamps to 0.
            if (is_temp) begin
                mag_next = r_abs[13:0];
                neg_next = 1'b1;
            end else begin
                mag_next = 14'd0;
            end
        end
        ovf_next = (32'(mag_next) >= 32'(LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            is_temp     <= 1'b0;
            mplier      <= 16'd0;
            mcand       <= 31'd0;
            acc         <= 31'd0;
            mag         <= 14'd0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            bcd         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            displaydata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_temp <= com_sig;
                        mplier  <= com_sig ? 16'd17572 : 16'd12500;
                        mcand   <= {15'd0, readData[15:2], 2'b00};
                        acc     <= 31'd0;
                        cnt     <= 4'd0;
                        busy    <= 1'b1;
                        state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= S_SUB;
                end
                S_SUB: begin
                    mag   <= mag_next;
                    neg_r <= neg_next;
                    ovf_r <= ovf_next;
                    bcd   <= '0;
                    cnt   <= 4'd0;
                    state <= S_BCD;
                end
                S_BCD: begin
                    bcd <= {bcd_adj[BW-2:0], mag[13]};
                    mag <= mag << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) state <= S_DONE;
                end
                S_DONE: begin
                    displaydata <= ovf_r ? {DIGITS{4'h9}} : bcd[DW-1:0];
                    negative    <= neg_r;
                    overflow    <= ovf_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
